pid_release_ctrl: RTL and testbench

Coprocessor-side counterpart of the packet MMU. Accepts the PID/header notifications the MMU emits after storing a packet, queues them in arrival order, and for each one issues a single-cycle PID retrieval request back to the MMU. It then collects the returned beats and forwards them to egress. Single-beat (ctl 0x04) packets, which the MMU never stores, are replayed from the queue in order without a retrieval request.

---
 rtl/pid_release_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pid_release_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_release_ctrl.sv
// pid_release_ctrl: queues packet-MMU notifications in arrival order.
// Stored packets are fetched back from the MMU with a one-cycle PID request and
// their beats are forwarded to egress. Single-beat packets are replayed from the
// queued header without a request.
module pid_release_ctrl #(
  parameter int unsigned DESC_DEPTH_BITS = 4,
  parameter int unsigned TIMEOUT         = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_pid,
  input  logic [8:0]   in_pid,
  input  logic [7:0]   in_ctl,
  input  logic [511:0] in_header,
  output logic         out_valid_pid_req,
  output logic [8:0]   out_pid_req,
  output logic [7:0]   out_pid_len,
  input  logic         in_valid_pkt,
  input  logic [7:0]   in_pkt_ctl,
  input  logic [511:0] in_pkt_data,
  output logic         out_valid,
  output logic [7:0]   out_ctl,
  output logic [511:0] out_data,
  output logic         out_nearly_full,
  output logic [15:0]  err_cnt
);

  localparam int unsigned DEPTH = 1 << DESC_DEPTH_BITS;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam logic [DESC_DEPTH_BITS:0] Q_FULL = (DESC_DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DESC_DEPTH_BITS:0] Q_NF   = (DESC_DEPTH_BITS + 1)'(DEPTH - 2);
  localparam logic [TW-1:0]            TMAX   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BYPASS, REQ, STREAM} state_t;

  typedef struct packed {
    logic [8:0]   pid;
    logic [5:0]   beats;
    logic         single;
    logic [511:0] header;
  } desc_t;

  desc_t                      mem [DEPTH];
  desc_t                      head;
  logic [DESC_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [DESC_DEPTH_BITS:0]   count, count_next;

  state_t       state;
  logic [8:0]   cur_pid;
  logic [5:0]   cur_beats;
  logic [511:0] cur_header;
  logic [5:0]   beat_cnt, beat_nxt;
  logic [TW-1:0] timer;

  logic        legal_ctl, is_single, q_full, q_empty, push, pop;
  logic        oversize, timeout_ev, stray;
  logic [15:0] len;
  logic [5:0]  beats_calc;
  logic [2:0]  err_inc;
  logic [16:0] err_sum;

  // Notification decode, beat count, queue control and error accounting
  always_comb begin
    len        = in_header[15:0];
    oversize   = len > 16'd2048;
    if (len == 16'd0)  beats_calc = 6'd1;
    else if (oversize) beats_calc = 6'd32;
    else               beats_calc = 6'((len + 16'd63) >> 6);

    is_single  = in_ctl == 8'h04;
    legal_ctl  = is_single || (in_ctl == 8'h01);
    q_full     = count == Q_FULL;
    q_empty    = count == '0;
    push       = in_valid_pid && legal_ctl && !q_full;
    pop        = (state == IDLE) && !q_empty;
    head       = mem[rd_ptr];
    beat_nxt   = beat_cnt + 6'd1;
    timeout_ev = (state == STREAM) && !in_valid_pkt && (timer == TMAX);
    stray      = in_valid_pkt && (state != STREAM);

    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;

    // Several error sources can fire in the same cycle; each counts once.
    err_inc = 3'(in_valid_pid && !legal_ctl)
            + 3'(in_valid_pid && legal_ctl && q_full)
            + 3'(push && !is_single && oversize)
            + 3'(timeout_ev)
            + 3'(stray);
    err_sum = {1'b0, err_cnt} + 17'(err_inc);
  end

  // Descriptor storage (no reset needed; validity is tracked by count)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_pid, beats_calc, is_single, in_header};
  end

  // Queue pointers, occupancy, nearly-full flag and saturating error counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      out_nearly_full <= 1'b0;
      err_cnt         <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count           <= count_next;
      out_nearly_full <= count_next >= Q_NF;
      err_cnt         <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  // Release FSM with registered request and egress outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cur_pid           <= '0;
      cur_beats         <= '0;
      cur_header        <= '0;
      beat_cnt          <= '0;
      timer             <= '0;
      out_valid_pid_req <= 1'b0;
      out_pid_req       <= '0;
      out_pid_len       <= '0;
      out_valid         <= 1'b0;
      out_ctl           <= '0;
      out_data          <= '0;
    end else begin
      out_valid_pid_req <= 1'b0;
      out_pid_req       <= '0;
      out_pid_len       <= '0;
      out_valid         <= 1'b0;
      out_ctl           <= '0;
      out_data          <= '0;
      case (state)
        IDLE: begin
          if (pop) begin
            cur_pid    <= head.pid;
            cur_beats  <= head.beats;
            cur_header <= head.header;
            state      <= head.single ? BYPASS : REQ;
          end
        end
        BYPASS: begin
          out_valid <= 1'b1;
          out_ctl   <= 8'h04;
          out_data  <= cur_header;
          state     <= IDLE;
        end
        REQ: begin
          out_valid_pid_req <= 1'b1;
          out_pid_req       <= cur_pid;
          out_pid_len       <= {2'b00, cur_beats};
          beat_cnt          <= '0;
          timer             <= '0;
          state             <= STREAM;
        end
        STREAM: begin
          if (in_valid_pkt) begin
            out_valid <= 1'b1;
            out_ctl   <= in_pkt_ctl;
            out_data  <= in_pkt_data;
            beat_cnt  <= beat_nxt;
            timer     <= '0;
            if ((in_pkt_ctl == 8'h03) || (beat_nxt == cur_beats)) state <= IDLE;
          end else if (timeout_ev) begin
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_release_ctrl.sv
// Testbench for pid_release_ctrl: cycle table for the basic flows, then
// hand-written sequences with a small MMU responder for ordering, queue-full,
// timeout and reset cases.
module tb_pid_release_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid_pid;
  logic [8:0]   in_pid;
  logic [7:0]   in_ctl;
  logic [511:0] in_header;
  logic         out_valid_pid_req;
  logic [8:0]   out_pid_req;
  logic [7:0]   out_pid_len;
  logic         in_valid_pkt;
  logic [7:0]   in_pkt_ctl;
  logic [511:0] in_pkt_data;
  logic         out_valid;
  logic [7:0]   out_ctl;
  logic [511:0] out_data;
  logic         out_nearly_full;
  logic [15:0]  err_cnt;

  // bench-driven beat and MMU-model beat, merged onto the DUT inputs
  logic         tb_pv;
  logic [7:0]   tb_pctl;
  logic [511:0] tb_pdat;
  logic         mmu_pv = 1'b0;
  logic [7:0]   mmu_ctl = '0;
  logic [511:0] mmu_dat = '0;
  bit           mmu_en = 1'b0, mmu_stall = 1'b0;
  int           mmu_left = 0, mmu_idx = 0;
  logic [8:0]   mmu_pid = '0;

  assign in_valid_pkt = tb_pv | mmu_pv;
  assign in_pkt_ctl   = tb_pv ? tb_pctl : mmu_ctl;
  assign in_pkt_data  = tb_pv ? tb_pdat : mmu_dat;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {logic [7:0] ctl; logic [511:0] data; int cyc;} eg_t;
  typedef struct {logic [8:0] pid; logic [7:0] len; int cyc;} rq_t;
  eg_t eg_q[$];
  rq_t rq_q[$];

  typedef struct {
    bit vp; logic [7:0] vctl; logic [8:0] vpid; logic [511:0] vhdr;
    bit pv; logic [7:0] pctl; logic [511:0] pdat;
    bit ev; logic [7:0] ectl; logic [511:0] edat;
    bit er; logic [8:0] erpid; logic [7:0] erlen;
    logic [15:0] eerr;
  } vec_t;
  vec_t vecs[$];

  pid_release_ctrl #(.DESC_DEPTH_BITS(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid_pid(in_valid_pid), .in_pid(in_pid), .in_ctl(in_ctl), .in_header(in_header),
    .out_valid_pid_req(out_valid_pid_req), .out_pid_req(out_pid_req), .out_pid_len(out_pid_len),
    .in_valid_pkt(in_valid_pkt), .in_pkt_ctl(in_pkt_ctl), .in_pkt_data(in_pkt_data),
    .out_valid(out_valid), .out_ctl(out_ctl), .out_data(out_data),
    .out_nearly_full(out_nearly_full), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] H(input logic [15:0] tag, input logic [15:0] len);
    return {{31{tag}}, len};
  endfunction

  function automatic logic [511:0] B(input logic [15:0] tag);
    return {32{tag}};
  endfunction

  function automatic logic [511:0] bdat(input logic [8:0] pid, input int idx);
    return B({7'(idx), pid});
  endfunction

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    in_valid_pid = 1'b0; in_pid = '0; in_ctl = '0; in_header = '0;
    tb_pv = 1'b0; tb_pctl = '0; tb_pdat = '0;
  endtask

  task automatic notify(input logic [7:0] ctl, input logic [8:0] pid, input logic [511:0] hdr);
    in_valid_pid = 1'b1; in_ctl = ctl; in_pid = pid; in_header = hdr;
  endtask

  task automatic row(input bit vp, input logic [7:0] vctl, input logic [8:0] vpid, input logic [511:0] vhdr,
                     input bit pv, input logic [7:0] pctl, input logic [511:0] pdat,
                     input bit ev, input logic [7:0] ectl, input logic [511:0] edat,
                     input bit er, input logic [8:0] erpid, input logic [7:0] erlen,
                     input logic [15:0] eerr);
    vecs.push_back('{vp, vctl, vpid, vhdr, pv, pctl, pdat, ev, ectl, edat, er, erpid, erlen, eerr});
  endtask

  task automatic wait_eg(input int n, input int budget, input string name);
    for (int i = 0; i < budget && eg_q.size() < n; i++) tick;
    check(name, eg_q.size() >= n, 1);
  endtask

  task automatic wait_rq(input int n, input int budget, input string name);
    for (int i = 0; i < budget && rq_q.size() < n; i++) tick;
    check(name, rq_q.size() >= n, 1);
  endtask

  // MMU responder: after a request, returns len beats (01, 02.., 03 last)
  initial begin
    forever begin
      @(posedge clk); #1;
      mmu_pv = 1'b0; mmu_ctl = '0; mmu_dat = '0;
      if (mmu_left != 0) begin
        if (!mmu_stall) begin
          mmu_pv  = 1'b1;
          mmu_ctl = (mmu_left == 1) ? 8'h03 : (mmu_idx == 0) ? 8'h01 : 8'h02;
          mmu_dat = bdat(mmu_pid, mmu_idx);
          mmu_idx++;
          mmu_left--;
        end
      end else if (mmu_en && out_valid_pid_req) begin
        mmu_pid  = out_pid_req;
        mmu_left = int'(out_pid_len);
        mmu_idx  = 0;
      end
    end
  end

  // Egress and request recorder
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) eg_q.push_back('{out_ctl, out_data, cyc});
      if (out_valid_pid_req) rq_q.push_back('{out_pid_req, out_pid_len, cyc});
    end
  end

  initial begin
    clear_in;
    reset = 1'b1;
    repeat (3) tick;
    check("reset outputs", {out_valid_pid_req, out_pid_req, out_pid_len, out_valid, out_ctl,
                            out_data, out_nearly_full, err_cnt}, '0);
    reset = 1'b0;

    // vp ctl pid hdr | pv pctl pdat | exp: ev ectl edat | er pid len | err
    row(1, 8'h04, 0, H(16'h00AB, 8),    0, 0, '0,          0, 0, '0,                    0, 0, 0, 0);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 0);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 0);
    row(0, 0, 0, '0,                    0, 0, '0,          1, 8'h04, H(16'h00AB, 8),    0, 0, 0, 0);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 0);
    row(1, 8'h01, 5, H(16'h0055, 200),  0, 0, '0,          0, 0, '0,                    0, 0, 0, 0);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 0);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 0);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    1, 5, 4, 0);
    row(0, 0, 0, '0,                    1, 8'h01, B(1),    0, 0, '0,                    0, 0, 0, 0);
    row(0, 0, 0, '0,                    1, 8'h02, B(2),    1, 8'h01, B(1),              0, 0, 0, 0);
    row(0, 0, 0, '0,                    1, 8'h02, B(3),    1, 8'h02, B(2),              0, 0, 0, 0);
    row(0, 0, 0, '0,                    1, 8'h03, B(4),    1, 8'h02, B(3),              0, 0, 0, 0);
    row(0, 0, 0, '0,                    0, 0, '0,          1, 8'h03, B(4),              0, 0, 0, 0);
    row(0, 0, 0, '0,                    1, 8'h01, B(5),    0, 0, '0,                    0, 0, 0, 0);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 1);
    row(1, 8'h02, 6, H(16'h0066, 100),  0, 0, '0,          0, 0, '0,                    0, 0, 0, 1);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 2);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 2);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 2);
    row(1, 8'h01, 3, H(16'h0033, 0),    0, 0, '0,          0, 0, '0,                    0, 0, 0, 2);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 2);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 2);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    1, 3, 1, 2);
    row(0, 0, 0, '0,                    1, 8'h03, B(6),    0, 0, '0,                    0, 0, 0, 2);
    row(0, 0, 0, '0,                    0, 0, '0,          1, 8'h03, B(6),              0, 0, 0, 2);
    row(1, 8'h01, 9, H(16'h0099, 3000), 0, 0, '0,          0, 0, '0,                    0, 0, 0, 2);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 3);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 3);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    1, 9, 32, 3);
    row(0, 0, 0, '0,                    1, 8'h03, B(7),    0, 0, '0,                    0, 0, 0, 3);
    row(0, 0, 0, '0,                    0, 0, '0,          1, 8'h03, B(7),              0, 0, 0, 3);
    row(1, 8'h01, 9'h1FF, H(16'h0077, 128), 0, 0, '0,      0, 0, '0,                    0, 0, 0, 3);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 3);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 3);
    row(0, 0, 0, '0,                    1, 8'h01, B(8),    0, 0, '0,                    1, 9'h1FF, 2, 3);
    row(0, 0, 0, '0,                    1, 8'h02, B(9),    1, 8'h01, B(8),              0, 0, 0, 3);
    row(0, 0, 0, '0,                    1, 8'h02, B(10),   1, 8'h02, B(9),              0, 0, 0, 3);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 4);
    row(1, 8'h01, 2, H(16'h0022, 2048), 0, 0, '0,          0, 0, '0,                    0, 0, 0, 4);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 4);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 4);
    row(0, 0, 0, '0,                    1, 8'h03, B(11),   0, 0, '0,                    1, 2, 32, 4);
    row(0, 0, 0, '0,                    0, 0, '0,          1, 8'h03, B(11),             0, 0, 0, 4);
    row(0, 0, 0, '0,                    0, 0, '0,          0, 0, '0,                    0, 0, 0, 4);

    foreach (vecs[i]) begin
      tick;
      check($sformatf("vec%0d", i),
            {out_valid, out_ctl, out_data, out_valid_pid_req, out_pid_req, out_pid_len, err_cnt},
            {vecs[i].ev, vecs[i].ectl, vecs[i].edat, vecs[i].er, vecs[i].erpid, vecs[i].erlen, vecs[i].eerr});
      in_valid_pid = vecs[i].vp; in_ctl = vecs[i].vctl; in_pid = vecs[i].vpid; in_header = vecs[i].vhdr;
      tb_pv = vecs[i].pv; tb_pctl = vecs[i].pctl; tb_pdat = vecs[i].pdat;
    end
    tick;
    clear_in;

    // Interleaved stored / single / stored notifications keep arrival order
    eg_q.delete(); rq_q.delete();
    mmu_en = 1'b1;
    tick; notify(8'h01, 7, H(16'h0707, 128));
    tick; notify(8'h04, 0, H(16'h0505, 8));
    tick; notify(8'h01, 9, H(16'h0909, 64));
    tick; clear_in;
    wait_eg(4, 100, "interleave egress count");
    repeat (4) tick;
    check("interleave egress total", eg_q.size(), 4);
    if (eg_q.size() >= 4) begin
      check("interleave beat0", {eg_q[0].ctl, eg_q[0].data}, {8'h01, bdat(7, 0)});
      check("interleave beat1", {eg_q[1].ctl, eg_q[1].data}, {8'h03, bdat(7, 1)});
      check("interleave single", {eg_q[2].ctl, eg_q[2].data}, {8'h04, H(16'h0505, 8)});
      check("interleave beat3", {eg_q[3].ctl, eg_q[3].data}, {8'h03, bdat(9, 0)});
    end
    check("interleave req count", rq_q.size(), 2);
    if (rq_q.size() >= 2 && eg_q.size() >= 2) begin
      check("interleave req0", {rq_q[0].pid, rq_q[0].len}, {9'd7, 8'd2});
      check("interleave req1", {rq_q[1].pid, rq_q[1].len}, {9'd9, 8'd1});
      check("pid9 req after pid7 end", rq_q[1].cyc > eg_q[1].cyc, 1);
    end
    check("interleave err", err_cnt, 16'd4);

    // Queue fills behind a stalled stream; 17th notification is dropped
    eg_q.delete(); rq_q.delete();
    mmu_stall = 1'b1;
    tick; notify(8'h01, 20, H(16'h2020, 64));
    tick; clear_in;
    wait_rq(1, 20, "stall req seen");
    for (int i = 0; i < 16; i++) begin
      notify(8'h01, 9'(21 + i), H(16'(i), 64));
      tick;
      check($sformatf("nearly_full after %0d", i + 1), out_nearly_full, (i + 1) >= 14);
    end
    notify(8'h01, 37, H(16'h3737, 64));
    tick;
    clear_in;
    check("drop on full err", err_cnt, 16'd5);
    tick;
    mmu_stall = 1'b0;
    wait_eg(17, 300, "full drain count");
    repeat (6) tick;
    check("full drain total", eg_q.size(), 17);
    for (int k = 0; k < 17; k++) begin
      if (k < eg_q.size())
        check($sformatf("drain order %0d", k), {eg_q[k].ctl, eg_q[k].data}, {8'h03, bdat(9'(20 + k), 0)});
    end
    check("drain err", err_cnt, 16'd5);
    check("drain nearly_full", out_nearly_full, 1'b0);

    // Silent MMU: timeout then the next request proceeds; late beat is stray
    eg_q.delete(); rq_q.delete();
    mmu_en = 1'b0;
    tick; notify(8'h01, 40, H(16'h4040, 64));
    tick; notify(8'h01, 41, H(16'h4141, 64));
    tick; clear_in;
    wait_rq(1, 20, "timeout first req");
    repeat (3) tick;
    mmu_en = 1'b1;
    wait_rq(2, 120, "timeout second req");
    if (rq_q.size() >= 2) begin
      check("timeout next pid", rq_q[1].pid, 9'd41);
      check("timeout req spacing", rq_q[1].cyc - rq_q[0].cyc, 66);
    end
    check("timeout err", err_cnt, 16'd6);
    wait_eg(1, 20, "timeout next egress");
    if (eg_q.size() >= 1) check("timeout next data", eg_q[0].data, bdat(41, 0));
    tick;
    tb_pv = 1'b1; tb_pctl = 8'h03; tb_pdat = bdat(40, 0);
    tick;
    clear_in;
    tick;
    check("late beat err", err_cnt, 16'd7);
    check("late beat no egress", eg_q.size(), 1);

    // Reset mid-stream clears everything; leftover beats are stray
    eg_q.delete(); rq_q.delete();
    tick; notify(8'h01, 50, H(16'h5050, 640));
    tick; clear_in;
    wait_eg(3, 40, "reset stream started");
    #2;
    reset = 1'b1;
    mmu_left = 0;
    mmu_en = 1'b0;
    #1;
    check("reset async clear", {out_valid_pid_req, out_pid_req, out_pid_len, out_valid, out_ctl,
                                out_data, out_nearly_full, err_cnt}, '0);
    tick;
    check("reset held", {out_valid_pid_req, out_pid_req, out_pid_len, out_valid, out_ctl,
                         out_data, out_nearly_full, err_cnt}, '0);
    eg_q.delete();
    #2;
    reset = 1'b0;
    tick;
    tb_pv = 1'b1; tb_pctl = 8'h02; tb_pdat = bdat(50, 5);
    tick;
    tb_pdat = bdat(50, 6);
    tick;
    clear_in;
    tick;
    check("post-reset stray err", err_cnt, 16'd2);
    check("post-reset no egress", eg_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
